// File: rtl/alu_core_pkg.sv
// Shared RV32I opcode/funct3 constants and ALU operation encoding for the ALU block.
// Pure definitions: no latency and no flow control apply.
package alu_core_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_SLL     = 3'b001;
    localparam logic [2:0] FNC_SLT     = 3'b010;
    localparam logic [2:0] FNC_SLTU    = 3'b011;
    localparam logic [2:0] FNC_XOR     = 3'b100;
    localparam logic [2:0] FNC_SRL_SRA = 3'b101;
    localparam logic [2:0] FNC_OR      = 3'b110;
    localparam logic [2:0] FNC_AND     = 3'b111;

    localparam logic FNC2_SRL = 1'b0;
    localparam logic FNC2_SRA = 1'b1;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_XXX    = 4'd15
    } alu_op_t;

endpackage

// File: rtl/alu_decode.sv
// Decodes opcode/funct3/instr[30] into an ALU operation.
// Latency: combinational; no backpressure (always accepts, no handshake).
module alu_decode
    import alu_core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    input  logic       add_rshift_type,
    output alu_op_t    ALUop
);

    alu_op_t ari_op;

    // Immediate arithmetic has no SUBI, so bit 30 only selects SUB for R-type.
    always_comb begin
        ari_op = ALU_ADD;
        case (funct)
            FNC_ADD_SUB: ari_op = (opcode == OPC_ARI_RTYPE && add_rshift_type) ? ALU_SUB : ALU_ADD;
            FNC_SLL:     ari_op = ALU_SLL;
            FNC_SLT:     ari_op = ALU_SLT;
            FNC_SLTU:    ari_op = ALU_SLTU;
            FNC_XOR:     ari_op = ALU_XOR;
            FNC_SRL_SRA: ari_op = (add_rshift_type == FNC2_SRA) ? ALU_SRA : ALU_SRL;
            FNC_OR:      ari_op = ALU_OR;
            FNC_AND:     ari_op = ALU_AND;
            default:     ari_op = ALU_XXX;
        endcase
    end

    always_comb begin
        ALUop = ALU_XXX;
        case (opcode)
            OPC_LUI:                      ALUop = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD,
            OPC_STORE:                    ALUop = ALU_ADD;
            OPC_ARI_ITYPE, OPC_ARI_RTYPE: ALUop = ari_op;
            default:                      ALUop = ALU_XXX;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// RV32I ALU: decoder plus combinational datapath, with a registered copy of result/zero.
// Latency: Out/Zero combinational, Out_q/Zero_q one cycle; no backpressure (captures every edge).
module alu_core
    import alu_core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct,
    input  logic             add_rshift_type,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [3:0]       ALUop,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic [WIDTH-1:0] Out_q,
    output logic             Zero_q
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t          op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sra_res;

    alu_decode u_decode (
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .ALUop           (op)
    );

    assign ALUop   = op;
    // Only the low log2(WIDTH) bits of B form the shift amount.
    assign shamt   = B[SHW-1:0];
    assign sra_res = $signed(A) >>> shamt;

    always_comb begin
        Out = '0;
        case (op)
            ALU_ADD:    Out = A + B;
            ALU_SUB:    Out = A - B;
            ALU_AND:    Out = A & B;
            ALU_OR:     Out = A | B;
            ALU_XOR:    Out = A ^ B;
            ALU_SLT:    Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:   Out = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:    Out = A << shamt;
            ALU_SRL:    Out = A >> shamt;
            ALU_SRA:    Out = sra_res;
            ALU_COPY_B: Out = B;
            default:    Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Out_q  <= '0;
            Zero_q <= 1'b0;
        end else begin
            Out_q  <= Out;
            Zero_q <= Zero;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: decode, datapath corners and the output register.
module tb_alu_core;
    import alu_core_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic        Zero;
    logic [31:0] Out_q;
    logic        Zero_q;

    int checks   = 0;
    int failures = 0;

    alu_core #(.WIDTH(32)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out),
        .Zero            (Zero),
        .Out_q           (Out_q),
        .Zero_q          (Zero_q)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] fn, input logic b30,
                         input logic [31:0] a, input logic [31:0] b);
        opcode          = opc;
        funct           = fn;
        add_rshift_type = b30;
        A               = a;
        B               = b;
    endtask

    // Drives one vector and checks the combinational outputs in the same cycle.
    task automatic vec(input string tag, input logic [6:0] opc, input logic [2:0] fn,
                       input logic b30, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] exp_op, input logic [31:0] exp_out,
                       input logic exp_zero);
        drive(opc, fn, b30, a, b);
        #1;
        check({tag, ".op"},   {28'd0, ALUop}, {28'd0, exp_op});
        check({tag, ".out"},  Out, exp_out);
        check({tag, ".zero"}, {31'd0, Zero}, {31'd0, exp_zero});
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drive(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'h1234_0000, 32'h0000_5678);
        tick;
        check("rst.out_q",  Out_q, 32'h0);
        check("rst.zero_q", {31'd0, Zero_q}, 32'h0);
        // Combinational path is live even while reset is held.
        #1;
        check("rst.comb_out", Out, 32'h1234_5678);

        vec("lui", OPC_LUI, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            32'h8000_0001, 32'hFFFF_8123, 4'd10, 32'hFFFF_8123, 1'b0);
        vec("sub", OPC_ARI_RTYPE, 3'b000, 1'b1, 32'h5, 32'h5, 4'd1, 32'h0, 1'b1);
        vec("addi_b30", OPC_ARI_ITYPE, 3'b000, 1'b1, 32'h5, 32'h5, 4'd0, 32'hA, 1'b0);
        vec("add_wrap", OPC_ARI_RTYPE, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h2, 4'd0, 32'h1, 1'b0);
        vec("sub_wrap", OPC_ARI_RTYPE, 3'b000, 1'b1, 32'h0, 32'h1, 4'd1, 32'hFFFF_FFFF, 1'b0);
        vec("slt", OPC_ARI_RTYPE, 3'b010, 1'b0, 32'h8000_0000, 32'h1, 4'd5, 32'h1, 1'b0);
        vec("sltu", OPC_ARI_RTYPE, 3'b011, 1'b0, 32'h8000_0000, 32'h1, 4'd6, 32'h0, 1'b1);
        vec("slti_b30", OPC_ARI_ITYPE, 3'b010, 1'b1, 32'h8000_0000, 32'h1, 4'd5, 32'h1, 1'b0);
        vec("sra", OPC_ARI_RTYPE, 3'b101, 1'b1, 32'hF000_FFFF, 32'hFFFF_FFEF, 4'd9, 32'hFFFF_E001, 1'b0);
        vec("srl", OPC_ARI_ITYPE, 3'b101, 1'b0, 32'hF000_FFFF, 32'hFFFF_FFEF, 4'd8, 32'h0001_E001, 1'b0);
        vec("sll", OPC_ARI_RTYPE, 3'b001, 1'b1, 32'hF000_FFFF, 32'hFFFF_FFEF, 4'd7, 32'h7FFF_8000, 1'b0);
        vec("and", OPC_ARI_RTYPE, 3'b111, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd2, 32'h00F0_1200, 1'b0);
        vec("or",  OPC_ARI_ITYPE, 3'b110, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd3, 32'hFFF0_FF34, 1'b0);
        vec("xor", OPC_ARI_RTYPE, 3'b100, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd4, 32'hFF00_ED34, 1'b0);
        vec("jal", OPC_JAL, 3'b101, 1'b1, 32'h0000_1000, 32'h0000_0008, 4'd0, 32'h0000_1008, 1'b0);
        vec("store", OPC_STORE, 3'b010, 1'b1, 32'h0000_0100, 32'hFFFF_FFFC, 4'd0, 32'h0000_00FC, 1'b0);
        vec("illegal", 7'b0000000, 3'b000, 1'b0, 32'h5, 32'h7, 4'd15, 32'h0, 1'b1);

        drive(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'h1, 32'h2);
        Reset = 1'b1;
        tick;
        check("rst2.out_q",  Out_q, 32'h0);
        check("rst2.zero_q", {31'd0, Zero_q}, 32'h0);
        Reset = 1'b0;
        tick;
        check("cap.out_q",  Out_q, 32'h3);
        check("cap.zero_q", {31'd0, Zero_q}, 32'h0);

        drive(OPC_ARI_RTYPE, 3'b000, 1'b1, 32'h5, 32'h5);
        tick;
        check("cap_zero.out_q",  Out_q, 32'h0);
        check("cap_zero.zero_q", {31'd0, Zero_q}, 32'h1);

        drive(OPC_LUI, 3'b000, 1'b0, 32'h0, 32'hABCD_E000);
        tick;
        check("cap_lui.out_q", Out_q, 32'hABCD_E000);
        Reset = 1'b1;
        tick;
        check("mid_rst.out_q", Out_q, 32'h0);
        Reset = 1'b0;
        tick;
        check("resume.out_q", Out_q, 32'hABCD_E000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
